nemesis_rom_arbiter: RTL



---
 rtl/nemesis_rom_pkg.sv | 14 +
 rtl/nemesis_rom_slot.sv | 38 +++
 rtl/nemesis_rom_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/nemesis_rom_pkg.sv
// Shared state/owner encodings and default address map for the Nemesis ROM arbiter.
package nemesis_rom_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
  typedef enum logic [1:0] {OWN_MAIN, OWN_Z80, OWN_DBG} owner_e;

  localparam int unsigned MAIN_AW_DEF   = 17;
  localparam int unsigned Z80_AW_DEF    = 14;
  localparam int unsigned SDRAM_AW_DEF  = 22;
  localparam logic [21:0] MAIN_BASE_DEF = 22'h000000;
  localparam logic [21:0] Z80_BASE_DEF  = 22'h040000;
  localparam int unsigned TIMEOUT_DEF   = 255;

endpackage

// File: rtl/nemesis_rom_slot.sv
// Single-entry read cache for one requester: last fetched address, its word and a valid bit.
module nemesis_rom_slot
  import nemesis_rom_pkg::*;
#(
  parameter int unsigned AW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [15:0]   wdata_i,
  input  logic [AW-1:0] addr_i,
  output logic          hit_o,
  output logic          lsb_o,
  output logic [15:0]   data_o
);

  logic [AW-1:0] addr_q;
  logic [15:0]   data_q;
  logic          valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (wr_i) begin
      addr_q  <= waddr_i;
      data_q  <= wdata_i;
      valid_q <= 1'b1;
    end
  end

  assign hit_o  = valid_q && (addr_q == addr_i);
  assign lsb_o  = addr_q[0];
  assign data_o = data_q;

endmodule

// File: rtl/nemesis_rom_arbiter.sv
// Arbitrates main CPU, Z80 and debug peek reads onto one SDRAM ROM port,
// each requester backed by a single-entry slot.
module nemesis_rom_arbiter
  import nemesis_rom_pkg::*;
#(
  parameter int unsigned            MAIN_AW   = MAIN_AW_DEF,
  parameter int unsigned            Z80_AW    = Z80_AW_DEF,
  parameter int unsigned            SDRAM_AW  = SDRAM_AW_DEF,
  parameter logic [SDRAM_AW-1:0]    MAIN_BASE = MAIN_BASE_DEF,
  parameter logic [SDRAM_AW-1:0]    Z80_BASE  = Z80_BASE_DEF,
  parameter int unsigned            TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_main_cs,
  input  logic [MAIN_AW-1:0]  i_main_addr,
  output logic                o_main_ok,
  output logic [15:0]         o_main_data,
  input  logic                i_z80_cs,
  input  logic [Z80_AW-1:0]   i_z80_addr,
  output logic                o_z80_ok,
  output logic [7:0]          o_z80_data,
  input  logic [7:0]          i_debug_bus,
  output logic [7:0]          o_debug_view,
  output logic                o_sdram_req,
  output logic [SDRAM_AW-1:0] o_sdram_addr,
  input  logic                i_sdram_ack,
  input  logic                i_sdram_dok,
  input  logic [15:0]         i_sdram_data,
  output logic                o_timeout
);

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic                  req_q, req_d;
  logic [SDRAM_AW-1:0]   saddr_q, saddr_d;
  logic [MAIN_AW-1:0]    raddr_q, raddr_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [1:0]            fair_q, fair_d;
  logic                  tmo_q, tmo_d;
  logic [7:0]            dbg_q;
  logic                  dbg_pend_q, dbg_pend_d;

  logic                  main_hit, z80_hit, dbg_hit_unused;
  logic                  main_lsb_unused, z80_lsb, dbg_lsb;
  logic [15:0]           main_word, z80_word, dbg_word;
  logic                  main_pend, z80_pend;
  logic                  done, wr_main, wr_z80, wr_dbg, expire;

  nemesis_rom_slot #(.AW(MAIN_AW)) u_main_slot (
    .clk_i(i_clk), .rst_ni(i_rst_n), .wr_i(wr_main), .waddr_i(raddr_q),
    .wdata_i(i_sdram_data), .addr_i(i_main_addr), .hit_o(main_hit),
    .lsb_o(main_lsb_unused), .data_o(main_word)
  );

  nemesis_rom_slot #(.AW(Z80_AW)) u_z80_slot (
    .clk_i(i_clk), .rst_ni(i_rst_n), .wr_i(wr_z80), .waddr_i(raddr_q[Z80_AW-1:0]),
    .wdata_i(i_sdram_data), .addr_i(i_z80_addr), .hit_o(z80_hit),
    .lsb_o(z80_lsb), .data_o(z80_word)
  );

  nemesis_rom_slot #(.AW(8)) u_dbg_slot (
    .clk_i(i_clk), .rst_ni(i_rst_n), .wr_i(wr_dbg), .waddr_i(raddr_q[7:0]),
    .wdata_i(i_sdram_data), .addr_i(i_debug_bus), .hit_o(dbg_hit_unused),
    .lsb_o(dbg_lsb), .data_o(dbg_word)
  );

  assign main_pend = i_main_cs && !main_hit;
  assign z80_pend  = i_z80_cs && !z80_hit;
  assign done      = (state_q == WAIT) && i_sdram_dok;
  assign wr_main   = done && (owner_q == OWN_MAIN);
  assign wr_z80    = done && (owner_q == OWN_Z80);
  assign wr_dbg    = done && (owner_q == OWN_DBG);
  assign expire    = (cnt_q + 8'd1) == 8'(TIMEOUT);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    req_d      = req_q;
    saddr_d    = saddr_q;
    raddr_d    = raddr_q;
    cnt_d      = cnt_q;
    fair_d     = fair_q;
    tmo_d      = tmo_q;
    dbg_pend_d = dbg_pend_q;

    // A new bus value outranks clearing, so a peek changed mid-fetch is re-issued.
    if (wr_dbg && (raddr_q[7:0] == i_debug_bus)) dbg_pend_d = 1'b0;
    if (i_debug_bus != dbg_q) dbg_pend_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (z80_pend && ((fair_q == 2'd2) || !main_pend)) begin
          owner_d = OWN_Z80;
          raddr_d = MAIN_AW'(i_z80_addr);
          saddr_d = Z80_BASE + SDRAM_AW'(i_z80_addr[Z80_AW-1:1]);
          fair_d  = '0;
          req_d   = 1'b1;
          state_d = REQ;
        end else if (main_pend) begin
          owner_d = OWN_MAIN;
          raddr_d = i_main_addr;
          saddr_d = MAIN_BASE + SDRAM_AW'(i_main_addr);
          fair_d  = z80_pend ? fair_q + 2'd1 : '0;
          req_d   = 1'b1;
          state_d = REQ;
        end else if (dbg_pend_q) begin
          owner_d = OWN_DBG;
          raddr_d = MAIN_AW'(i_debug_bus);
          saddr_d = MAIN_BASE + SDRAM_AW'(i_debug_bus[7:1]);
          fair_d  = '0;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (i_sdram_ack) begin
          req_d   = 1'b0;
          state_d = WAIT;
        end else if (expire) begin
          req_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (i_sdram_dok) begin
          state_d = IDLE;
        end else if (expire) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      owner_q    <= OWN_MAIN;
      req_q      <= 1'b0;
      saddr_q    <= '0;
      raddr_q    <= '0;
      cnt_q      <= '0;
      fair_q     <= '0;
      tmo_q      <= 1'b0;
      dbg_q      <= '0;
      dbg_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      req_q      <= req_d;
      saddr_q    <= saddr_d;
      raddr_q    <= raddr_d;
      cnt_q      <= cnt_d;
      fair_q     <= fair_d;
      tmo_q      <= tmo_d;
      dbg_q      <= i_debug_bus;
      dbg_pend_q <= dbg_pend_d;
    end
  end

  assign o_sdram_req  = req_q;
  assign o_sdram_addr = saddr_q;
  assign o_timeout    = tmo_q;
  assign o_main_ok    = i_main_cs && main_hit;
  assign o_main_data  = main_word;
  assign o_z80_ok     = i_z80_cs && z80_hit;
  // Z80 is little-endian within the word, the 68k debug view big-endian.
  assign o_z80_data   = z80_lsb ? z80_word[15:8] : z80_word[7:0];
  assign o_debug_view = dbg_lsb ? dbg_word[7:0] : dbg_word[15:8];

endmodule
